// File: rtl/alu_pkg.sv
// Shared ALU control codes, alu_op encodings and issue-unit FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] OP_LDST   = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of alu_op/funct3/funct7b5 into ALU control code,
// branch kind and an illegal-combination flag.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ctrl,
  output logic       is_branch,
  output logic       branch_ne,
  output logic       illegal
);

  // Decode table; unsupported funct3 values fall through to ILLEGAL.
  always_comb begin
    ctrl      = ALU_ILLEGAL;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      OP_LDST: ctrl = ALU_ADD;
      OP_BRANCH: begin
        // Branches always compare by subtraction; only BEQ/BNE are supported.
        ctrl      = ALU_SUB;
        is_branch = 1'b1;
        case (funct3)
          3'b000:  branch_ne = 1'b0;
          3'b001:  branch_ne = 1'b1;
          default: illegal   = 1'b1;
        endcase
      end
      OP_RTYPE: begin
        case (funct3)
          3'b000:  ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl = ALU_AND;
          3'b110:  ctrl = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: bit 30 belongs to the immediate, so it never selects SUB.
        case (funct3)
          3'b000:  ctrl = ALU_ADD;
          3'b111:  ctrl = ALU_AND;
          3'b110:  ctrl = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Request/response wrapper around the combinational ALU: registers the
// decoded request, drives the ALU for one cycle, then holds the response.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_alu_op,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [XLEN-1:0]  req_op1,
  input  logic [XLEN-1:0]  req_op2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t state_reg, state_next;

  logic [XLEN-1:0]  op1_reg, op2_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [3:0]       ctrl_reg;
  logic             is_branch_reg, branch_ne_reg, illegal_reg;

  logic [XLEN-1:0]  rsp_result_reg;
  logic             rsp_zero_reg, rsp_taken_reg, rsp_illegal_reg;
  logic [TAG_W-1:0] rsp_tag_reg;

  logic [3:0] dec_ctrl;
  logic       dec_is_branch, dec_branch_ne, dec_illegal;
  logic       accept;

  alu_ctrl_dec u_dec (
    .alu_op    (req_alu_op),
    .funct3    (req_funct3),
    .funct7b5  (req_funct7b5),
    .ctrl      (dec_ctrl),
    .is_branch (dec_is_branch),
    .branch_ne (dec_branch_ne),
    .illegal   (dec_illegal)
  );

  // Next state and handshake outputs; RESP only frees the slot when the
  // consumer takes the response, allowing back-to-back accepts.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_next = req_valid ? S_EXEC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Request capture on accept, response capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_reg         <= '0;
      op2_reg         <= '0;
      tag_reg         <= '0;
      ctrl_reg        <= ALU_AND;
      is_branch_reg   <= 1'b0;
      branch_ne_reg   <= 1'b0;
      illegal_reg     <= 1'b0;
      rsp_result_reg  <= '0;
      rsp_zero_reg    <= 1'b0;
      rsp_taken_reg   <= 1'b0;
      rsp_illegal_reg <= 1'b0;
      rsp_tag_reg     <= '0;
    end else begin
      if (accept) begin
        op1_reg       <= req_op1;
        op2_reg       <= req_op2;
        tag_reg       <= req_tag;
        ctrl_reg      <= dec_ctrl;
        is_branch_reg <= dec_is_branch;
        branch_ne_reg <= dec_branch_ne;
        illegal_reg   <= dec_illegal;
      end
      if (state_reg == S_EXEC) begin
        rsp_result_reg  <= alu_result;
        rsp_zero_reg    <= alu_zero;
        // An unsupported branch condition never reports taken.
        rsp_taken_reg   <= is_branch_reg & ~illegal_reg & (alu_zero ^ branch_ne_reg);
        rsp_illegal_reg <= illegal_reg;
        rsp_tag_reg     <= tag_reg;
      end
    end
  end

  assign alu_in1     = op1_reg;
  assign alu_in2     = op2_reg;
  assign alu_ctrl    = ctrl_reg;
  assign rsp_result  = rsp_result_reg;
  assign rsp_zero    = rsp_zero_reg;
  assign rsp_taken   = rsp_taken_reg;
  assign rsp_illegal = rsp_illegal_reg;
  assign rsp_tag     = rsp_tag_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural combinational ALU.
module tb_alu_issue_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_alu_op;
  logic [2:0]       req_funct3;
  logic             req_funct7b5;
  logic [XLEN-1:0]  req_op1, req_op2;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  alu_in1, alu_in2;
  logic [3:0]       alu_ctrl;
  logic [XLEN-1:0]  alu_result;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready;
  logic [XLEN-1:0]  rsp_result;
  logic             rsp_zero, rsp_taken, rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_taken(rsp_taken),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
  );

  // Behavioural ALU: unknown codes return 0.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  tag;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic drive_req(input vec_t v);
    req_valid    = 1'b1;
    req_alu_op   = v.op;
    req_funct3   = v.f3;
    req_funct7b5 = v.f7b5;
    req_op1      = v.op1;
    req_op2      = v.op2;
    req_tag      = v.tag;
  endtask

  vec_t va, vb;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_alu_op = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_op1 = '0; req_op2 = '0; req_tag = '0;

    //             op     f3     f7  op1           op2           tag  ctrl     result        z  t  ill
    vecs[0]  = '{2'b10, 3'b000, 0, 32'd7,        32'd5,        4'd1, 4'b0010, 32'd12,       0, 0, 0};
    vecs[1]  = '{2'b10, 3'b000, 1, 32'd9,        32'd9,        4'd2, 4'b0110, 32'd0,        1, 0, 0};
    vecs[2]  = '{2'b11, 3'b000, 1, 32'd9,        32'd9,        4'd3, 4'b0010, 32'd18,       0, 0, 0};
    vecs[3]  = '{2'b01, 3'b000, 0, 32'h1234,     32'h1234,     4'd4, 4'b0110, 32'd0,        1, 1, 0};
    vecs[4]  = '{2'b01, 3'b001, 0, 32'h1234,     32'h1234,     4'd5, 4'b0110, 32'd0,        1, 0, 0};
    vecs[5]  = '{2'b01, 3'b001, 0, 32'd3,        32'd4,        4'd6, 4'b0110, 32'hFFFFFFFF, 0, 1, 0};
    vecs[6]  = '{2'b01, 3'b100, 0, 32'd5,        32'd5,        4'd7, 4'b0110, 32'd0,        1, 0, 1};
    vecs[7]  = '{2'b10, 3'b001, 0, 32'd5,        32'd3,        4'd8, 4'b1111, 32'd0,        1, 0, 1};
    vecs[8]  = '{2'b10, 3'b111, 0, 32'hF0F0,     32'hFF00,     4'd9, 4'b0000, 32'hF000,     0, 0, 0};
    vecs[9]  = '{2'b11, 3'b110, 0, 32'hF0,       32'h0F,       4'hA, 4'b0001, 32'hFF,       0, 0, 0};
    vecs[10] = '{2'b00, 3'b010, 1, 32'd100,      32'hFFFFFFFC, 4'hB, 4'b0010, 32'd96,       0, 0, 0};
    vecs[11] = '{2'b11, 3'b001, 0, 32'd5,        32'd3,        4'hC, 4'b1111, 32'd0,        1, 0, 1};

    // Reset state (asynchronous, visible before any clock edge).
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Table-driven single transactions with rsp_ready held high.
    for (int i = 0; i < 12; i++) begin
      drive_req(vecs[i]);
      chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
      tick();                     // accept edge N
      req_valid = 1'b0;
      chk("exec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, vecs[i].ctrl});
      chk("exec_alu_in1", alu_in1, vecs[i].op1);
      chk("exec_alu_in2", alu_in2, vecs[i].op2);
      chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();                     // edge N+1
      chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("resp_result", rsp_result, vecs[i].result);
      chk("resp_zero", {31'd0, rsp_zero}, {31'd0, vecs[i].zero});
      chk("resp_taken", {31'd0, rsp_taken}, {31'd0, vecs[i].taken});
      chk("resp_illegal", {31'd0, rsp_illegal}, {31'd0, vecs[i].illegal});
      chk("resp_tag", {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
      $display("vec %0d: ctrl=%b result=0x%0h zero=%0b taken=%0b illegal=%0b tag=%0d",
               i, vecs[i].ctrl, rsp_result, rsp_zero, rsp_taken, rsp_illegal, rsp_tag);
      tick();                     // response taken, back to IDLE
      chk("back_idle_valid", {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure with a second request waiting, then back-to-back accept.
    va = '{2'b10, 3'b000, 0, 32'd7,  32'd5,  4'd1, 4'b0010, 32'd12,  0, 0, 0};
    vb = '{2'b10, 3'b111, 0, 32'hFF, 32'h0F, 4'd2, 4'b0000, 32'h0F,  0, 0, 0};
    rsp_ready = 1'b0;
    drive_req(va);
    tick();
    drive_req(vb);
    chk("bp_exec_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'd12);
      chk("bp_rsp_tag", {28'd0, rsp_tag}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", {31'd0, req_ready}, 32'd1);
    tick();                       // B accepted, back in EXEC
    req_valid = 1'b0;
    chk("b2b_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_exec_ctrl", {28'd0, alu_ctrl}, 32'd0);
    tick();
    chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp_tag", {28'd0, rsp_tag}, 32'd2);
    chk("b2b_rsp_result", rsp_result, 32'h0F);
    $display("backpressure: second response tag=%0d result=0x%0h", rsp_tag, rsp_result);
    tick();

    // Reset during EXEC clears the driven ALU registers immediately.
    drive_req(va);
    tick();
    req_valid = 1'b0;
    chk("rst_exec_pre_ctrl", {28'd0, alu_ctrl}, 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_exec_in1", alu_in1, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_exec_no_stale", {31'd0, rsp_valid}, 32'd0);
      chk("rst_exec_req_ready", {31'd0, req_ready}, 32'd1);
    end
    $display("reset during EXEC: transaction discarded");

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    drive_req(va);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_resp_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_resp_result", rsp_result, 32'd0);
    chk("rst_resp_tag", {28'd0, rsp_tag}, 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_resp_no_stale", {31'd0, rsp_valid}, 32'd0);
    end
    $display("reset during RESP: response dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
